// File: rtl/npu_pkg.sv
// Shared types and constants for the convolution front end.
// CONV_WINDOW_LOADER_PAD_EN selects zero-padded ("same") window scanning.
package npu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    PUBLISH,
    WAIT,
    FINISH
  } state_e;

  localparam int IMG_W_DEF       = 28;
  localparam int IMG_H_DEF       = 28;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int KK_DEF          = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;

  localparam logic BANK_WIN1 = 1'b0;
  localparam logic BANK_WIN2 = 1'b1;

  localparam int POS_W = 8;

`ifdef CONV_WINDOW_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  // Border width around the image; zero when padding is compiled out.
  function automatic int pad_of(input int k);
    return PAD_EN ? (k - 1) / 2 : 0;
  endfunction

endpackage

// File: rtl/conv_window_loader_addr_gen.sv
// Window position / element counters and incremental BRAM address generation.
// With CONV_WINDOW_LOADER_PAD_EN the origin shifts by the border and an in-bounds flag is produced.
module conv_window_addr_gen
  import npu_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int IMG_W           = IMG_W_DEF,
  parameter int IMG_H           = IMG_H_DEF,
  parameter int KERNEL_SIZE     = KERNEL_SIZE_DEF,
  parameter int WIN_ADDR_WIDTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0] base_i,
  input  logic                       step_i,
  input  logic                       next_win_i,
  output logic [BRAM_ADDR_WIDTH-1:0] addr_o,
  output logic [WIN_ADDR_WIDTH-1:0]  elem_o,
  output logic                       inb_o,
  output logic [POS_W-1:0]           row_o,
  output logic [POS_W-1:0]           col_o,
  output logic                       last_win_o
);

  localparam int PAD = pad_of(KERNEL_SIZE);
  localparam logic [POS_W-1:0] COL_LAST = POS_W'(IMG_W - KERNEL_SIZE + 2 * PAD);
  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(IMG_H - KERNEL_SIZE + 2 * PAD);
  localparam logic [WIN_ADDR_WIDTH-1:0] C_LAST = WIN_ADDR_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] W_A = BRAM_ADDR_WIDTH'(IMG_W);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ORIGIN_OFF = BRAM_ADDR_WIDTH'(PAD * IMG_W + PAD);

  logic [POS_W-1:0]           row_q, col_q;
  logic [WIN_ADDR_WIDTH-1:0]  r_q, c_q, k_q;
  logic [BRAM_ADDR_WIDTH-1:0] row_start_q, win_base_q, elem_row_q;
  logic [BRAM_ADDR_WIDTH-1:0] row_start_d, win_base_d;

  // row_start tracks column 0 of the current window row; win_base the window's
  // top-left element; elem_row the start of the element row being read.
  assign row_start_d = row_start_q + W_A;
  assign win_base_d  = win_base_q + BRAM_ADDR_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q       <= '0;
      col_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      row_start_q <= '0;
      win_base_q  <= '0;
      elem_row_q  <= '0;
    end else if (start_i) begin
      row_q       <= '0;
      col_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      row_start_q <= base_i - ORIGIN_OFF;
      win_base_q  <= base_i - ORIGIN_OFF;
      elem_row_q  <= base_i - ORIGIN_OFF;
    end else if (next_win_i) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      if (col_q == COL_LAST) begin
        col_q       <= '0;
        row_q       <= row_q + POS_W'(1);
        row_start_q <= row_start_d;
        win_base_q  <= row_start_d;
        elem_row_q  <= row_start_d;
      end else begin
        col_q      <= col_q + POS_W'(1);
        win_base_q <= win_base_d;
        elem_row_q <= win_base_d;
      end
    end else if (step_i) begin
      k_q <= k_q + WIN_ADDR_WIDTH'(1);
      if (c_q == C_LAST) begin
        c_q        <= '0;
        r_q        <= r_q + WIN_ADDR_WIDTH'(1);
        elem_row_q <= elem_row_q + W_A;
      end else begin
        c_q <= c_q + WIN_ADDR_WIDTH'(1);
      end
    end
  end

  assign addr_o     = elem_row_q + BRAM_ADDR_WIDTH'(c_q);
  assign elem_o     = k_q;
  assign row_o      = row_q;
  assign col_o      = col_q;
  assign last_win_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef CONV_WINDOW_LOADER_PAD_EN
  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] H_S = SW'(IMG_H);
  localparam logic signed [SW-1:0] W_S = SW'(IMG_W);
  localparam logic signed [SW-1:0] P_S = SW'(PAD);

  logic signed [SW-1:0] y_s, x_s;

  assign y_s   = $signed(SW'(row_q)) + $signed(SW'(r_q)) - P_S;
  assign x_s   = $signed(SW'(col_q)) + $signed(SW'(c_q)) - P_S;
  assign inb_o = !y_s[SW-1] && (y_s < H_S) && !x_s[SW-1] && (x_s < W_S);
`else
  assign inb_o = 1'b1;
`endif

endmodule

// File: rtl/conv_window_loader.sv
// Builds KxK stride-1 windows from image BRAM into ping-pong window banks.
// Define CONV_WINDOW_LOADER_PAD_EN for zero-padded "same" scanning.
module conv_window_loader
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int IMG_W           = IMG_W_DEF,
  parameter int IMG_H           = IMG_H_DEF,
  parameter int KERNEL_SIZE     = KERNEL_SIZE_DEF,
  parameter int WIN_ADDR_WIDTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_img_base_addr,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [DATA_WIDTH-1:0]      i_bram_rd_data,
  output logic                       o_win1_wr_en,
  output logic                       o_win2_wr_en,
  output logic [WIN_ADDR_WIDTH-1:0]  o_win_wr_addr,
  output logic [DATA_WIDTH-1:0]      o_win_wr_data,
  output logic [1:0]                 o_win_ready,
  input  logic [1:0]                 i_win_release,
  output logic [7:0]                 o_win_row,
  output logic [7:0]                 o_win_col,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [WIN_ADDR_WIDTH-1:0] ELEM_LAST = WIN_ADDR_WIDTH'(KK - 1);

  state_e                     state_q;
  logic                       bank_q;
  logic [1:0]                 ready_q, ready_d;
  logic                       busy_q, done_q;
  logic [POS_W-1:0]           win_row_q, win_col_q;
  logic                       wr1_q, wr2_q, inb_q;
  logic [WIN_ADDR_WIDTH-1:0]  wr_addr_q;

  logic                       ag_start, ag_step, ag_next, ag_inb, ag_last;
  logic [BRAM_ADDR_WIDTH-1:0] ag_addr;
  logic [WIN_ADDR_WIDTH-1:0]  ag_elem;
  logic [POS_W-1:0]           ag_row, ag_col;

  assign ag_start = (state_q == IDLE) && i_start;
  assign ag_step  = (state_q == LOAD);
  assign ag_next  = (state_q == PUBLISH);
  assign ready_d  = ready_q & ~i_win_release;

  conv_window_addr_gen #(
    .BRAM_ADDR_WIDTH(BRAM_ADDR_WIDTH),
    .IMG_W          (IMG_W),
    .IMG_H          (IMG_H),
    .KERNEL_SIZE    (KERNEL_SIZE),
    .WIN_ADDR_WIDTH (WIN_ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i     (i_clk),
    .rst_ni    (i_rst),
    .start_i   (ag_start),
    .base_i    (i_img_base_addr),
    .step_i    (ag_step),
    .next_win_i(ag_next),
    .addr_o    (ag_addr),
    .elem_o    (ag_elem),
    .inb_o     (ag_inb),
    .row_o     (ag_row),
    .col_o     (ag_col),
    .last_win_o(ag_last)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      bank_q    <= BANK_WIN1;
      ready_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      wr1_q     <= 1'b0;
      wr2_q     <= 1'b0;
      wr_addr_q <= '0;
      inb_q     <= 1'b0;
    end else begin
      // BRAM has one cycle of read latency, so the write trails its address.
      wr1_q     <= (state_q == LOAD) && (bank_q == BANK_WIN1);
      wr2_q     <= (state_q == LOAD) && (bank_q == BANK_WIN2);
      wr_addr_q <= (state_q == LOAD) ? ag_elem : '0;
      inb_q     <= ag_inb;
      ready_q   <= ready_d;

      case (state_q)
        IDLE: begin
          if (i_start) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            bank_q  <= BANK_WIN1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (ag_elem == ELEM_LAST) state_q <= DRAIN;
        end
        DRAIN: state_q <= PUBLISH;
        PUBLISH: begin
          ready_q[bank_q] <= 1'b1;
          win_row_q       <= ag_row;
          win_col_q       <= ag_col;
          bank_q          <= ~bank_q;
          if (ag_last) begin
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else if (ready_q[~bank_q]) begin
            state_q <= WAIT;
          end else begin
            state_q <= LOAD;
          end
        end
        WAIT: begin
          if (!ready_q[bank_q]) state_q <= LOAD;
        end
        FINISH: begin
          if (ready_q == 2'b00) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_bram_rd_addr = (state_q == LOAD) ? ag_addr : '0;
  assign o_win1_wr_en   = wr1_q;
  assign o_win2_wr_en   = wr2_q;
  assign o_win_wr_addr  = wr_addr_q;
  // Out-of-bounds (padding) slots and idle cycles present zero.
  assign o_win_wr_data  = ((wr1_q || wr2_q) && inb_q) ? i_bram_rd_data : '0;
  assign o_win_ready    = ready_q;
  assign o_win_row      = win_row_q;
  assign o_win_col      = win_col_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_conv_window_loader.sv
// Self-checking bench for conv_window_loader (default and CONV_WINDOW_LOADER_PAD_EN builds).
module tb_conv_window_loader;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int IW = 28;
  localparam int IH = 28;
  localparam int K  = 3;
  localparam int WA = 4;
  localparam int KK = K * K;

`ifdef CONV_WINDOW_LOADER_PAD_EN
  localparam int P        = 1;
  localparam int NTOT_LIT = 784;
  localparam int LAST_LIT = 27;
  int lit_w1 [9] = '{0, 0, 0, 0, 0, 1, 0, 28, 29};
  int lit_w2 [9] = '{0, 0, 0, 0, 1, 2, 28, 29, 30};
`else
  localparam int P        = 0;
  localparam int NTOT_LIT = 676;
  localparam int LAST_LIT = 25;
  int lit_w1 [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  int lit_w2 [9] = '{1, 2, 3, 29, 30, 31, 57, 58, 59};
`endif

  localparam int NC = IW - K + 1 + 2 * P;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr1, wr2;
  logic [WA-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    ready;
  logic [1:0]    rel_man;
  logic [1:0]    rel_auto = 2'b00;
  logic [1:0]    rel;
  logic [7:0]    wrow, wcol;
  logic          busy, done;

  logic [DW-1:0] mem [1024];

  assign rel = rel_man | rel_auto;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  conv_window_loader dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_start        (start),
    .i_img_base_addr(base),
    .o_bram_rd_addr (rd_addr),
    .i_bram_rd_data (rd_data),
    .o_win1_wr_en   (wr1),
    .o_win2_wr_en   (wr2),
    .o_win_wr_addr  (wr_addr),
    .o_win_wr_data  (wr_data),
    .o_win_ready    (ready),
    .i_win_release  (rel),
    .o_win_row      (wrow),
    .o_win_col      (wcol),
    .o_busy         (busy),
    .o_done         (done)
  );

  int  n_cmp  = 0;
  int  n_fail = 0;
  int  win_w  = 0;
  int  elem_w = 0;
  int  pub_cnt = 0;
  int  n_wr   = 0;
  int  base_m = 0;
  time t_start = 0;
  time last_pub_t = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [1:0]    prev_rdy = 2'b00;
  int  img1 [9];
  int  img2 [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Window w in raster order, element k: where it lives in the image and what it holds.
  function automatic void exp_elem(input int w, input int k, output logic inb,
                                   output logic [AW-1:0] a, output logic [DW-1:0] d);
    int y, x;
    y   = w / NC - P + k / K;
    x   = w % NC - P + k % K;
    inb = (y >= 0) && (y < IH) && (x >= 0) && (x < IW);
    a   = AW'(base_m + y * IW + x);
    d   = inb ? mem[a] : '0;
  endfunction

  // Consumer model: releases each bank a few cycles after it becomes ready.
  logic       auto_en = 1'b0;
  logic [1:0] auto_prev = 2'b00;
  int         rel_cnt [2];
  always @(negedge clk) begin
    rel_auto = 2'b00;
    if (!rst_n || !auto_en) begin
      rel_cnt[0] = 0;
      rel_cnt[1] = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (ready[b] && !auto_prev[b]) rel_cnt[b] = 3;
        else if (rel_cnt[b] > 0) begin
          rel_cnt[b]--;
          if (rel_cnt[b] == 0) rel_auto[b] = 1'b1;
        end
      end
    end
    auto_prev = ready;
  end

  always @(negedge clk) begin : cmp
    logic          inb_e;
    logic [AW-1:0] a_e;
    logic [DW-1:0] d_e;
    logic [1:0]    rise;
    if (!rst_n) begin
      win_w    = 0;
      elem_w   = 0;
      pub_cnt  = 0;
      prev_rdy = 2'b00;
    end else begin
      if (start && !busy) begin
        win_w   = 0;
        elem_w  = 0;
        pub_cnt = 0;
        base_m  = int'(base);
      end
      if (wr1 || wr2) begin
        exp_elem(win_w, elem_w, inb_e, a_e, d_e);
        chk("wr_bank", {30'd0, wr2, wr1}, (win_w % 2) ? 2 : 1);
        chk("wr_addr", wr_addr, elem_w);
        chk("wr_data", wr_data, d_e);
        if (inb_e) chk("rd_addr", prev_addr, a_e);
        if (wr1) img1[elem_w] = int'(wr_data);
        else     img2[elem_w] = int'(wr_data);
        n_wr++;
        elem_w++;
        if (elem_w == KK) begin
          elem_w = 0;
          win_w++;
        end
      end
      rise = ready & ~prev_rdy;
      if (rise != 2'b00) begin
        chk("pub_bank", rise, (pub_cnt % 2) ? 2 : 1);
        chk("pub_row", wrow, pub_cnt / NC);
        chk("pub_col", wcol, pub_cnt % NC);
        chk("pub_after_load", win_w, pub_cnt + 1);
        pub_cnt++;
        last_pub_t = $time - 5;
      end
      prev_rdy = ready;
    end
    prev_addr = rd_addr;
  end

  task automatic pulse_start(input logic [AW-1:0] b);
    base  = b;
    start = 1'b1;
    @(posedge clk);
    t_start = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_ready(input logic [1:0] v, input int budget, input string nm);
    int n;
    n = 0;
    while (ready !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, ready, v);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done, 1);
  endtask

  initial begin
    int nw, n;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    rst_n   = 1'b0;
    start   = 1'b0;
    base    = '0;
    rel_man = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", {wr2, wr1}, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_row", wrow, 0);
    chk("rst_col", wcol, 0);
    chk("rst_wr_data", wr_data, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_rd_addr", rd_addr, 0);
    chk("idle_no_wr", n_wr, 0);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    // Scan 1: first window, ping-pong stall, then free-running to completion.
    @(posedge clk); #1;
    pulse_start(10'd0);
    @(negedge clk);
    chk("busy_run", busy, 1);
    n = 0;
    while (ready == 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("first_ready", ready, 1);
    chk("first_latency", int'(($time - 5 - t_start) / 10), 11);
    chk("first_row", wrow, 0);
    chk("first_col", wcol, 0);
    for (int k = 0; k < KK; k++) chk("win1_lit", img1[k], lit_w1[k]);

    wait_ready(2'b11, 60, "both_ready");
    chk("second_row", wrow, 0);
    chk("second_col", wcol, 1);
    for (int k = 0; k < KK; k++) chk("win2_lit", img2[k], lit_w2[k]);
    nw = n_wr;
    repeat (30) @(negedge clk);
    chk("stall_no_wr", n_wr, nw);
    chk("stall_ready", ready, 3);
    chk("stall_busy", busy, 1);

    @(posedge clk); #1 rel_man = 2'b01;
    @(posedge clk); #1 rel_man = 2'b00;
    wait_ready(2'b10, 5, "release_w1");
    wait_ready(2'b11, 60, "third_ready");
    chk("third_row", wrow, 0);
    chk("third_col", wcol, 2);

    @(posedge clk); #1 auto_en = 1'b1; rel_man = 2'b11;
    @(posedge clk); #1 rel_man = 2'b00;
    wait_done(20000, "scan1_done");
    chk("scan1_pubs", pub_cnt, NTOT_LIT);
    chk("scan1_last_row", wrow, LAST_LIT);
    chk("scan1_last_col", wcol, LAST_LIT);
    chk("scan1_busy", busy, 0);
    chk("scan1_ready", ready, 0);

    // Scan 2: base near the top of the address space, no consumer stall.
    @(posedge clk); #1;
    pulse_start(10'd1000);
    @(negedge clk);
    chk("scan2_done_clr", done, 0);
`ifdef CONV_WINDOW_LOADER_PAD_EN
    repeat (4) @(negedge clk);
    chk("scan2_centre_addr", rd_addr, 1000);
`else
    chk("scan2_first_addr", rd_addr, 1000);
    repeat (6) @(negedge clk);
    chk("scan2_wrap_addr", rd_addr, 32);
`endif
    wait_done(12000, "scan2_done");
    chk("scan2_pubs", pub_cnt, NTOT_LIT);
    chk("scan2_cycles", int'((last_pub_t - t_start) / 10), 11 * NTOT_LIT);

    // Scan 3: reset in the middle of a scan, then restart.
    @(posedge clk); #1;
    pulse_start(10'd0);
    n = 0;
    while (pub_cnt < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_100", pub_cnt, 100);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr", {wr2, wr1}, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_row", wrow, 0);
    chk("midrst_col", wcol, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start(10'd0);
    n = 0;
    while (ready == 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("restart_ready", ready, 1);
    chk("restart_latency", int'(($time - 5 - t_start) / 10), 11);
    chk("restart_row", wrow, 0);
    chk("restart_col", wcol, 0);
    for (int k = 0; k < KK; k++) chk("restart_win1_lit", img1[k], lit_w1[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
